uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
- Shares the memory-mapped UART transmitter between N_REQ byte producers, for example the core's print path and a debug/trace source.
- Requesters push bytes through valid/ready. A round-robin arbiter admits one byte per cycle into a shared FIFO.
- A sequencer FSM drains the FIFO into the UART. It polls the UART status register (`uart_status_addr`, bit0 = tx_busy) and writes to `uart_tx_addr` only when the transmitter is idle.
- Sits between the requesters and the UART's r/w port in the peripheral region.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- FIFO_DEPTH, 8, byte FIFO depth; must be a power of two.
- FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- req_valid_i  input  N_REQ  per-requester byte valid
- req_data_i  input  N_REQ*8  byte k is at [8k+7:8k]
- req_ready_o  output  N_REQ  byte k accepted when valid&ready
- uart_r_addr_o  output  `mem_addr_bus  UART read address
- uart_r_enable_o  output  1  UART read enable
- uart_w_addr_o  output  `mem_addr_bus  UART write address
- uart_w_enable_o  output  1  UART write enable
- uart_data_o  output  `data_bus  UART write data, {24'b0, byte}
- uart_data_i  input  `data_bus  UART read data; registered, valid the cycle after the read
- fifo_count_o  output  FIFO_AW+1  current FIFO occupancy
- idle_o  output  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (clk edge with rst_n=0):
  - FSM to IDLE; FIFO pointers and count to 0; round-robin pointer to 0.
  - All outputs 0, except idle_o=1.
  - Reset mid-transfer abandons the FIFO contents and any pending write.
- Arbiter (combinational grant):
  - Searches from the rr pointer upward, with wrap, for the first asserted req_valid_i bit.
  - req_ready_o is one-hot on the granted requester when the FIFO is not full; otherwise it is all zero.
  - Ready never depends on a same-cycle pop; a full FIFO blocks pushes even in a cycle that pops.
  - On an accepted push the rr pointer becomes (granted index + 1) mod N_REQ. With no push, the pointer holds.
- FIFO:
  - Push writes at wr_ptr. Pop advances rd_ptr. Pointers wrap at FIFO_DEPTH.
  - count +1 on push only, -1 on pop only, unchanged when both happen in the same cycle.
  - fifo_count_o = count (registered).
- FSM (Moore; bus outputs decoded from state; r/w addresses are 0 whenever the matching enable is 0):
  - IDLE: if count != 0, go to POLL.
  - POLL: uart_r_enable_o=1, uart_r_addr_o=`uart_status_addr`; go to CHECK.
  - CHECK: sample uart_data_i[0]. If 1 (busy), go to POLL. If 0, go to WRITE.
  - WRITE: uart_w_enable_o=1, uart_w_addr_o=`uart_tx_addr`, uart_data_o={24'b0, FIFO head}; pop one byte; go to SETTLE.
  - SETTLE: one guard cycle so the UART's tx_busy is set before the next poll; go to IDLE.
- Latency:
  - A byte pushed into an empty FIFO with an idle UART appears on the UART write port 4 cycles after the accept edge (IDLE, POLL, CHECK, WRITE).
  - Minimum spacing between two UART writes is 5 cycles.
- Boundaries:
  - FSM never issues a write with an empty FIFO.
  - CHECK→POLL repeats indefinitely while busy; no timeout.
  - Bytes from one requester leave in acceptance order.

Optional Feature:
- Macro: UART_TX_SCHED_IRQ_EN.
- When defined, adds port irq_o (output, 1). It is a registered one-cycle pulse on the cycle after a SETTLE in which count is 0 and no push occurred, i.e. the last queued byte was handed to the UART. Reset value 0.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 for 2 clk edges with req_valid_i=2'b11 → req_ready_o=0 during reset, fifo_count_o=0, idle_o=1, all enables 0; after release, requester 0 is accepted first.
- Single byte: req0 pushes 8'hA5 with uart_data_i=0 → exactly one POLL read of `uart_status_addr`, then 4 cycles after accept a write to `uart_tx_addr` with data 32'h000000A5; idle_o returns to 1.
- Busy stall: hold uart_data_i[0]=1 for 10 cycles after the first POLL → POLL/CHECK alternates, no write; write occurs 1 cycle after the first CHECK that sees bit0=0.
- Round robin: both requesters continuously valid (req0 bytes 8'h10.., req1 bytes 8'h20..) → accepts alternate 0,1,0,1; UART writes in order 10,20,11,21.
- Full FIFO: push 8 bytes while busy=1 → fifo_count_o=8, req_ready_o=0; release busy → one pop, count 7, next push is accepted the following cycle.
- IRQ (UART_TX_SCHED_IRQ_EN defined): push 2 bytes → irq_o pulses exactly once, one cycle after the second write's SETTLE; no pulse if a new byte is pushed during that SETTLE.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if -- request and UART-bus bundle for uart_tx_sched.
//
// Signal groups:
//   requesters : req_valid_i / req_data_i (byte k at [8k+7:8k]) / req_ready_o
//   UART r/w   : uart_r_addr_o, uart_r_enable_o, uart_w_addr_o,
//                uart_w_enable_o, uart_data_o, uart_data_i (registered read data)
//   status     : fifo_count_o, idle_o, irq_o (only with UART_TX_SCHED_IRQ_EN)
//
// Modports:
//   master : the environment side (requesters and the UART). It drives the
//            *_i signals.
//   slave  : the scheduler. It drives the *_o signals.
//
// Optional macro: UART_TX_SCHED_IRQ_EN adds irq_o.
`ifndef UART_TX_SCHED_DEFS
`define UART_TX_SCHED_DEFS
`define MEM_ADDR_BUS 31:0
`define DATA_BUS 31:0
`define UART_TX_ADDR 32'h1000_0000
`define UART_STATUS_ADDR 32'h1000_0004
`endif

interface uart_tx_sched_if #(
  parameter int N_REQ   = 2,
  parameter int FIFO_AW = 3
) ();
  logic [N_REQ-1:0]   req_valid_i;
  logic [N_REQ*8-1:0] req_data_i;
  logic [N_REQ-1:0]   req_ready_o;
  logic [`MEM_ADDR_BUS] uart_r_addr_o;
  logic               uart_r_enable_o;
  logic [`MEM_ADDR_BUS] uart_w_addr_o;
  logic               uart_w_enable_o;
  logic [`DATA_BUS]   uart_data_o;
  logic [`DATA_BUS]   uart_data_i;
  logic [FIFO_AW:0]   fifo_count_o;
  logic               idle_o;
`ifdef UART_TX_SCHED_IRQ_EN
  logic               irq_o;
`endif

  modport master (
    output req_valid_i, req_data_i, uart_data_i,
    input  req_ready_o, uart_r_addr_o, uart_r_enable_o, uart_w_addr_o,
           uart_w_enable_o, uart_data_o, fifo_count_o, idle_o
`ifdef UART_TX_SCHED_IRQ_EN
    , input irq_o
`endif
  );

  modport slave (
    input  req_valid_i, req_data_i, uart_data_i,
    output req_ready_o, uart_r_addr_o, uart_r_enable_o, uart_w_addr_o,
           uart_w_enable_o, uart_data_o, fifo_count_o, idle_o
`ifdef UART_TX_SCHED_IRQ_EN
    , output irq_o
`endif
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched -- shares one memory-mapped UART transmitter between N_REQ
// byte producers.
//
// A round-robin arbiter admits at most one byte per cycle into a byte FIFO.
// A sequencer drains the FIFO. It polls the UART status register
// (bit0 = tx_busy) and writes the head byte only when the UART is idle.
//
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   bus    : uart_tx_sched_if.slave. Carries the requester valid/ready/data,
//            the UART read and write port, fifo_count_o and idle_o.
//
// Optional macro: UART_TX_SCHED_IRQ_EN adds irq_o. irq_o is a one-cycle pulse
// after the SETTLE cycle that hands the last queued byte to the UART.
`ifndef UART_TX_SCHED_DEFS
`define UART_TX_SCHED_DEFS
`define MEM_ADDR_BUS 31:0
`define DATA_BUS 31:0
`define UART_TX_ADDR 32'h1000_0000
`define UART_STATUS_ADDR 32'h1000_0004
`endif

module uart_tx_sched #(
  parameter int N_REQ      = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_sched_if.slave  bus
);
  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POLL   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;

  logic [2:0]          r_state;
  logic [RR_W-1:0]     r_rr;
  logic [FIFO_AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]    r_count;
  logic [7:0]          r_mem [FIFO_DEPTH];

  logic [2*N_REQ-1:0]  w_dbl;
  logic [N_REQ-1:0]    w_rot, w_onehot, w_rdy;
  logic [RR_W:0]       w_sum;
  logic [RR_W-1:0]     w_gidx, w_rr_nxt;
  logic                w_gnt_any, w_full, w_push, w_pop;
  logic [7:0]          w_push_byte;
  logic                w_unused;

  // Rotate the valid vector so that bit 0 is the requester at the rr pointer.
  // The first set bit of the rotated vector is the grant.
  assign w_dbl = {bus.req_valid_i, bus.req_valid_i} >> r_rr;
  assign w_rot = w_dbl[N_REQ-1:0];
  assign w_unused = ^{w_dbl[2*N_REQ-1:N_REQ], bus.uart_data_i[31:1]};

  always_comb begin
    w_gnt_any = 1'b0;
    w_gidx    = r_rr;
    w_sum     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_gnt_any && w_rot[i]) begin
        w_gnt_any = 1'b1;
        w_sum     = {1'b0, r_rr} + (RR_W+1)'(i);
        if (w_sum >= (RR_W+1)'(N_REQ)) w_sum = w_sum - (RR_W+1)'(N_REQ);
        w_gidx    = w_sum[RR_W-1:0];
      end
    end
  end

  always_comb begin
    w_onehot         = '0;
    w_onehot[w_gidx] = 1'b1;
  end

  always_comb begin
    w_push_byte = '0;
    for (int i = 0; i < N_REQ; i++)
      if (w_gidx == RR_W'(i)) w_push_byte = bus.req_data_i[8*i +: 8];
  end

  // Ready depends only on the registered count. A pop in the same cycle does
  // not open a slot. Ready is gated by reset so nothing is offered while
  // rst_n is low.
  assign w_full   = (r_count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign w_rdy    = (rst_n && w_gnt_any && !w_full) ? w_onehot : '0;
  assign w_push   = rst_n && w_gnt_any && !w_full;
  assign w_pop    = (r_state == S_WRITE);
  assign w_rr_nxt = (w_gidx == RR_W'(N_REQ-1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_rr     <= w_rr_nxt;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The byte storage needs no reset. Its contents are meaningless once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_byte;
  end

  // WRITE is reachable only through IDLE with count != 0. Only WRITE pops, so
  // the FIFO always holds at least one byte when a write is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else begin
      case (r_state)
        S_IDLE:   if (r_count != '0) r_state <= S_POLL;
        S_POLL:   r_state <= S_CHECK;
        S_CHECK:  r_state <= bus.uart_data_i[0] ? S_POLL : S_WRITE;
        S_WRITE:  r_state <= S_SETTLE;
        S_SETTLE: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o     = w_rdy;
  assign bus.uart_r_enable_o = (r_state == S_POLL);
  assign bus.uart_r_addr_o   = (r_state == S_POLL) ? `UART_STATUS_ADDR : '0;
  assign bus.uart_w_enable_o = (r_state == S_WRITE);
  assign bus.uart_w_addr_o   = (r_state == S_WRITE) ? `UART_TX_ADDR : '0;
  assign bus.uart_data_o     = (r_state == S_WRITE) ? {24'b0, r_mem[r_rd_ptr]} : '0;
  assign bus.fifo_count_o    = r_count;
  assign bus.idle_o          = (r_state == S_IDLE) && (r_count == '0);

`ifdef UART_TX_SCHED_IRQ_EN
  // In SETTLE the count already reflects the pop done in WRITE. A zero count
  // with no incoming push means the UART received the last queued byte.
  logic r_irq;
  always_ff @(posedge clk) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= (r_state == S_SETTLE) && (r_count == '0) && !w_push;
  end
  assign bus.irq_o = r_irq;
`endif
endmodule
